// File: rtl/axi4_pkg.sv
// Shared encodings for the AXI4 slave RAM: burst types, response codes and
// the state values of its read and write channel FSMs.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // RESET is held for the first cycle after reset release so that the
  // READY outputs stay low while resetn is asserted.
  localparam logic [1:0] W_RESET = 2'b00;
  localparam logic [1:0] W_IDLE  = 2'b01;
  localparam logic [1:0] W_DATA  = 2'b10;
  localparam logic [1:0] W_RESP  = 2'b11;

  localparam logic [1:0] R_RESET = 2'b00;
  localparam logic [1:0] R_IDLE  = 2'b01;
  localparam logic [1:0] R_DATA  = 2'b10;

  // WRAP and the reserved encoding both have bit 1 set.
  function automatic logic burst_is_error(input logic [1:0] burst);
    return burst[1];
  endfunction

endpackage

// File: rtl/axi4_slave_mem_core.sv
// Byte-enabled word array with one synchronous write port and one
// asynchronous read port; the only storage in the slave RAM.
module axi4_slave_mem_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // A same-cycle read sees the value from before the write.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 slave backed by a word memory: independent read and write FSMs,
// one outstanding transaction per channel, FIXED/INCR bursts.
module axi4_slave_ram
  import axi4_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic                        AXI_AWVALID,
  input  logic [3:0]                  AXI_AWID,
  input  logic [7:0]                  AXI_AWLEN,
  input  logic [2:0]                  AXI_AWSIZE,
  input  logic [1:0]                  AXI_AWBURST,
  input  logic [2:0]                  AXI_AWPROT,
  input  logic                        AXI_AWLOCK,
  input  logic [3:0]                  AXI_AWCACHE,
  input  logic [3:0]                  AXI_AWQOS,
  output logic                        AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                        AXI_WLAST,
  input  logic                        AXI_WVALID,
  output logic                        AXI_WREADY,
  output logic [1:0]                  AXI_BRESP,
  output logic [3:0]                  AXI_BID,
  output logic                        AXI_BVALID,
  input  logic                        AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic                        AXI_ARVALID,
  input  logic [3:0]                  AXI_ARID,
  input  logic [7:0]                  AXI_ARLEN,
  input  logic [2:0]                  AXI_ARSIZE,
  input  logic [1:0]                  AXI_ARBURST,
  input  logic [2:0]                  AXI_ARPROT,
  input  logic                        AXI_ARLOCK,
  input  logic [3:0]                  AXI_ARCACHE,
  input  logic [3:0]                  AXI_ARQOS,
  output logic                        AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [3:0]                  AXI_RID,
  output logic [1:0]                  AXI_RRESP,
  output logic                        AXI_RLAST,
  output logic                        AXI_RVALID,
  input  logic                        AXI_RREADY
);

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH/8);
  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
  localparam idx_t IDX_ONE = idx_t'(1);

  logic [1:0] w_state_q, w_state_d;
  idx_t       w_idx_q, w_idx_d;
  logic [3:0] w_id_q, w_id_d;
  logic [7:0] w_len_q, w_len_d;
  logic [7:0] w_cnt_q, w_cnt_d;
  logic       w_fixed_q, w_fixed_d;
  logic       w_err_q, w_err_d;
  logic       mem_we;

  logic [1:0] r_state_q, r_state_d;
  idx_t       r_idx_q, r_idx_d;
  logic [3:0] r_id_q, r_id_d;
  logic [7:0] r_len_q, r_len_d;
  logic [7:0] r_cnt_q, r_cnt_d;
  logic       r_fixed_q, r_fixed_d;
  logic       r_err_q, r_err_d;

  logic [AXI_DATA_WIDTH-1:0] mem_rdata;

  // Sideband fields and upper address bits have no effect on behaviour.
  logic unused_inputs;
  assign unused_inputs = ^{AXI_AWADDR, AXI_AWSIZE, AXI_AWPROT, AXI_AWLOCK,
                           AXI_AWCACHE, AXI_AWQOS, AXI_WLAST, AXI_ARADDR,
                           AXI_ARSIZE, AXI_ARPROT, AXI_ARLOCK, AXI_ARCACHE,
                           AXI_ARQOS};

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_RESET: w_state_d = W_IDLE;
      W_IDLE: begin
        if (AXI_AWVALID) begin
          w_idx_d   = AXI_AWADDR[ADDR_LSB +: MEM_DEPTH_LOG2];
          w_id_d    = AXI_AWID;
          w_len_d   = AXI_AWLEN;
          w_fixed_d = (AXI_AWBURST == BURST_FIXED);
          w_err_d   = burst_is_error(AXI_AWBURST);
          w_cnt_d   = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        // The burst ends on beat count alone; WLAST is not consulted.
        if (AXI_WVALID) begin
          mem_we  = 1'b1;
          w_cnt_d = w_cnt_q + 8'd1;
          if (!w_fixed_q) w_idx_d = w_idx_q + IDX_ONE;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: if (AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_RESET;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_fixed_d = r_fixed_q;
    r_err_d   = r_err_q;
    case (r_state_q)
      R_RESET: r_state_d = R_IDLE;
      R_IDLE: begin
        if (AXI_ARVALID) begin
          r_idx_d   = AXI_ARADDR[ADDR_LSB +: MEM_DEPTH_LOG2];
          r_id_d    = AXI_ARID;
          r_len_d   = AXI_ARLEN;
          r_fixed_d = (AXI_ARBURST == BURST_FIXED);
          r_err_d   = burst_is_error(AXI_ARBURST);
          r_cnt_d   = 8'd0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (AXI_RREADY) begin
          r_cnt_d = r_cnt_q + 8'd1;
          if (!r_fixed_q) r_idx_d = r_idx_q + IDX_ONE;
          if (r_cnt_q == r_len_q) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_RESET;
      w_idx_q   <= '0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      r_state_q <= R_RESET;
      r_idx_q   <= '0;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      r_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_fixed_q <= r_fixed_d;
      r_err_q   <= r_err_d;
    end
  end

  axi4_slave_mem_core #(
    .DATA_WIDTH(AXI_DATA_WIDTH),
    .DEPTH_LOG2(MEM_DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(w_idx_q),
    .wdata(AXI_WDATA),
    .wstrb(AXI_WSTRB),
    .raddr(r_idx_q),
    .rdata(mem_rdata)
  );

  assign AXI_AWREADY = (w_state_q == W_IDLE);
  assign AXI_WREADY  = (w_state_q == W_DATA);
  assign AXI_BVALID  = (w_state_q == W_RESP);
  assign AXI_BRESP   = (AXI_BVALID && w_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign AXI_BID     = AXI_BVALID ? w_id_q : 4'd0;

  assign AXI_ARREADY = (r_state_q == R_IDLE);
  assign AXI_RVALID  = (r_state_q == R_DATA);
  assign AXI_RDATA   = mem_rdata;
  assign AXI_RID     = AXI_RVALID ? r_id_q : 4'd0;
  assign AXI_RRESP   = (AXI_RVALID && r_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign AXI_RLAST   = AXI_RVALID && (r_cnt_q == r_len_q);

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Scoreboard bench for axi4_slave_ram: expected R beats are queued when a
// read is issued and compared against the beats the slave returns.
module tb_axi4_slave_ram;
  import axi4_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] AXI_AWADDR, AXI_ARADDR, AXI_WDATA, AXI_RDATA;
  logic        AXI_AWVALID, AXI_AWREADY, AXI_AWLOCK, AXI_ARVALID, AXI_ARREADY, AXI_ARLOCK;
  logic [3:0]  AXI_AWID, AXI_ARID, AXI_AWCACHE, AXI_AWQOS, AXI_ARCACHE, AXI_ARQOS, AXI_WSTRB;
  logic [7:0]  AXI_AWLEN, AXI_ARLEN;
  logic [2:0]  AXI_AWSIZE, AXI_AWPROT, AXI_ARSIZE, AXI_ARPROT;
  logic [1:0]  AXI_AWBURST, AXI_ARBURST, AXI_BRESP, AXI_RRESP;
  logic        AXI_WLAST, AXI_WVALID, AXI_WREADY, AXI_BVALID, AXI_BREADY;
  logic [3:0]  AXI_BID, AXI_RID;
  logic        AXI_RLAST, AXI_RVALID, AXI_RREADY;

  always #5 clk = ~clk;

  axi4_slave_ram #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .MEM_DEPTH_LOG2(8)) dut (
    .clk(clk), .resetn(resetn),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWID(AXI_AWID),
    .AXI_AWLEN(AXI_AWLEN), .AXI_AWSIZE(AXI_AWSIZE), .AXI_AWBURST(AXI_AWBURST),
    .AXI_AWPROT(AXI_AWPROT), .AXI_AWLOCK(AXI_AWLOCK), .AXI_AWCACHE(AXI_AWCACHE),
    .AXI_AWQOS(AXI_AWQOS), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BID(AXI_BID), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARID(AXI_ARID),
    .AXI_ARLEN(AXI_ARLEN), .AXI_ARSIZE(AXI_ARSIZE), .AXI_ARBURST(AXI_ARBURST),
    .AXI_ARPROT(AXI_ARPROT), .AXI_ARLOCK(AXI_ARLOCK), .AXI_ARCACHE(AXI_ARCACHE),
    .AXI_ARQOS(AXI_ARQOS), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RID(AXI_RID), .AXI_RRESP(AXI_RRESP),
    .AXI_RLAST(AXI_RLAST), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [31:0] model_mem [0:255];
  logic [31:0] wr_data [0:255];
  logic [3:0]  wr_strb [0:255];
  int          errors = 0;
  int          checks = 0;
  int          stall_bad, wready_wait, bvalid_wait, rvalid_wait;

  task automatic note_timeout(input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no handshake within budget, required one", what);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, output logic [1:0] bresp, output logic [3:0] bid);
    int n;
    logic [7:0] idx;
    bresp = 2'bxx;
    bid   = 4'bxxxx;
    AXI_AWADDR = addr; AXI_AWID = id; AXI_AWLEN = 8'(len); AXI_AWBURST = burst;
    AXI_AWSIZE = 3'd2; AXI_AWVALID = 1'b1;
    n = 0;
    while (!AXI_AWREADY && n < 100) begin @(negedge clk); n++; end
    if (!AXI_AWREADY) begin note_timeout("aw_handshake"); AXI_AWVALID = 1'b0; return; end
    @(negedge clk);
    AXI_AWVALID = 1'b0;
    idx = addr[9:2];
    for (int i = 0; i <= len; i++) begin
      AXI_WDATA = wr_data[i]; AXI_WSTRB = wr_strb[i]; AXI_WLAST = (i == len); AXI_WVALID = 1'b1;
      n = 0;
      while (!AXI_WREADY && n < 100) begin @(negedge clk); n++; end
      if (i == 0) wready_wait = n;
      if (!AXI_WREADY) begin note_timeout("w_beat"); AXI_WVALID = 1'b0; return; end
      for (int b = 0; b < 4; b++)
        if (wr_strb[i][b]) model_mem[idx][b*8 +: 8] = wr_data[i][b*8 +: 8];
      if (burst != BURST_FIXED) idx = idx + 8'd1;
      @(negedge clk);
    end
    AXI_WVALID = 1'b0; AXI_WLAST = 1'b0; AXI_BREADY = 1'b1;
    n = 0;
    while (!AXI_BVALID && n < 100) begin @(negedge clk); n++; end
    bvalid_wait = n;
    if (!AXI_BVALID) begin note_timeout("b_handshake"); AXI_BREADY = 1'b0; return; end
    bresp = AXI_BRESP;
    bid   = AXI_BID;
    @(negedge clk);
    AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                         input logic [1:0] burst, input bit toggle);
    int n, cyc, got;
    bit stalled;
    beat_t held, cur;
    AXI_ARADDR = addr; AXI_ARID = id; AXI_ARLEN = 8'(len); AXI_ARBURST = burst;
    AXI_ARSIZE = 3'd2; AXI_ARVALID = 1'b1;
    n = 0;
    while (!AXI_ARREADY && n < 100) begin @(negedge clk); n++; end
    if (!AXI_ARREADY) begin note_timeout("ar_handshake"); AXI_ARVALID = 1'b0; return; end
    @(negedge clk);
    AXI_ARVALID = 1'b0;
    cyc = 0; got = 0; stalled = 0; stall_bad = 0; rvalid_wait = -1;
    held = '0;
    while (got <= len && cyc < 2000) begin
      AXI_RREADY = toggle ? ((cyc % 2) == 1) : 1'b1;
      cur = {AXI_RDATA, AXI_RID, AXI_RRESP, AXI_RLAST};
      if (AXI_RVALID) begin
        if (rvalid_wait < 0) rvalid_wait = cyc;
        if (stalled && cur !== held) stall_bad++;
        if (AXI_RREADY) begin got_q.push_back(cur); got++; stalled = 0; end
        else begin held = cur; stalled = 1; end
      end
      @(negedge clk);
      cyc++;
    end
    AXI_RREADY = 1'b0;
    if (got <= len) note_timeout("r_beats");
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    outs = {AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_ARREADY, AXI_RVALID, AXI_RLAST,
            AXI_BRESP, AXI_RRESP, AXI_BID, AXI_RID};
    checks++;
    if (outs !== 18'd0) begin errors++; $display("[TB] FAIL reset_outputs: got %h required 0", outs); end
    resetn = 1'b1;
    checks++;
    if ({AXI_AWREADY, AXI_ARREADY} !== 2'b00) begin
      errors++; $display("[TB] FAIL ready_before_edge: got %b required 00", {AXI_AWREADY, AXI_ARREADY});
    end
    @(negedge clk);
    checks++;
    if ({AXI_AWREADY, AXI_ARREADY} !== 2'b11) begin
      errors++; $display("[TB] FAIL ready_after_edge: got %b required 11", {AXI_AWREADY, AXI_ARREADY});
    end
  endtask

  task automatic test_single();
    logic [1:0] bresp;
    logic [3:0] bid;
    beat_t e, g;
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    do_write(32'h10, 4'd3, 0, BURST_INCR, bresp, bid);
    checks++;
    if ({bresp, bid} !== {RESP_OKAY, 4'd3}) begin
      errors++; $display("[TB] FAIL single_b: got resp/id %h required %h", {bresp, bid}, {RESP_OKAY, 4'd3});
    end
    checks++;
    if (wready_wait !== 0 || bvalid_wait !== 0) begin
      errors++; $display("[TB] FAIL single_w_latency: got waits %0d/%0d required 0/0", wready_wait, bvalid_wait);
    end
    exp_q.push_back({32'hDEADBEEF, 4'd5, RESP_OKAY, 1'b1});
    do_read(32'h10, 4'd5, 0, BURST_INCR, 1'b0);
    checks++;
    if (rvalid_wait !== 0) begin errors++; $display("[TB] FAIL single_r_latency: got %0d required 0", rvalid_wait); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("[TB] FAIL single_r: got no beat required %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL single_r: got %h required %h", g, e); end end
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] bresp;
    logic [3:0] bid;
    beat_t e, g;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    do_write(32'h0, 4'd1, 3, BURST_INCR, bresp, bid);
    checks++;
    if (bresp !== RESP_OKAY) begin errors++; $display("[TB] FAIL incr_b: got %b required 00", bresp); end
    for (int i = 0; i < 4; i++) exp_q.push_back({32'(i + 1), 4'd2, RESP_OKAY, i == 3});
    do_read(32'h0, 4'd2, 3, BURST_INCR, 1'b1);
    checks++;
    if (stall_bad !== 0) begin errors++; $display("[TB] FAIL incr_stall_stable: got %0d changes required 0", stall_bad); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("[TB] FAIL incr_r: got no beat required %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL incr_r: got %h required %h", g, e); end end
    end
  endtask

  task automatic test_strobe_fixed();
    logic [1:0] bresp;
    logic [3:0] bid;
    beat_t e, g;
    wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'hF;
    wr_data[1] = 32'h55555555; wr_strb[1] = 4'hF;
    do_write(32'h20, 4'd4, 1, BURST_INCR, bresp, bid);
    wr_data[0] = 32'h11223344; wr_strb[0] = 4'h1;
    wr_data[1] = 32'hAABBCCDD; wr_strb[1] = 4'h8;
    do_write(32'h20, 4'd4, 1, BURST_FIXED, bresp, bid);
    exp_q.push_back({32'hAAFFFF44, 4'd6, RESP_OKAY, 1'b0});
    exp_q.push_back({32'h55555555, 4'd6, RESP_OKAY, 1'b1});
    do_read(32'h20, 4'd6, 1, BURST_INCR, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("[TB] FAIL strobe_fixed_r: got no beat required %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL strobe_fixed_r: got %h required %h", g, e); end end
    end
  endtask

  task automatic test_wrap_alias();
    logic [1:0] bresp;
    logic [3:0] bid;
    beat_t e, g;
    wr_data[0] = 32'd7; wr_strb[0] = 4'hF;
    wr_data[1] = 32'd9; wr_strb[1] = 4'hF;
    do_write(32'h3FC, 4'd7, 1, BURST_INCR, bresp, bid);
    exp_q.push_back({32'd7, 4'd8, RESP_OKAY, 1'b0});
    exp_q.push_back({32'd9, 4'd8, RESP_OKAY, 1'b1});
    do_read(32'h3FC, 4'd8, 1, BURST_INCR, 1'b0);
    exp_q.push_back({32'd9, 4'd9, RESP_OKAY, 1'b1});
    do_read(32'h0, 4'd9, 0, BURST_INCR, 1'b0);
    exp_q.push_back({32'd9, 4'd10, RESP_OKAY, 1'b1});
    do_read(32'h400, 4'd10, 0, BURST_INCR, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("[TB] FAIL wrap_alias_r: got no beat required %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL wrap_alias_r: got %h required %h", g, e); end end
    end
  endtask

  task automatic test_error_burst();
    logic [1:0] bresp;
    logic [3:0] bid;
    beat_t e, g;
    wr_data[0] = 32'hA1A1A1A1; wr_strb[0] = 4'hF;
    wr_data[1] = 32'hA2A2A2A2; wr_strb[1] = 4'hF;
    do_write(32'h100, 4'd11, 1, 2'b10, bresp, bid);
    checks++;
    if ({bresp, bid} !== {RESP_SLVERR, 4'd11}) begin
      errors++; $display("[TB] FAIL error_b: got resp/id %h required %h", {bresp, bid}, {RESP_SLVERR, 4'd11});
    end
    exp_q.push_back({32'hA1A1A1A1, 4'd12, RESP_SLVERR, 1'b0});
    exp_q.push_back({32'hA2A2A2A2, 4'd12, RESP_SLVERR, 1'b1});
    do_read(32'h100, 4'd12, 1, 2'b11, 1'b0);
    exp_q.push_back({32'hA1A1A1A1, 4'd13, RESP_OKAY, 1'b1});
    do_read(32'h100, 4'd13, 0, BURST_INCR, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("[TB] FAIL error_r: got no beat required %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL error_r: got %h required %h", g, e); end end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] bresp;
    logic [3:0] bid;
    logic [31:0] addr [0:3];
    int len [0:3];
    logic [7:0] idx;
    beat_t e, g;
    for (int k = 0; k < 4; k++) begin
      addr[k] = 32'h200 + 32'($urandom_range(0, 40)) * 4;
      len[k]  = $urandom_range(0, 5);
      for (int i = 0; i <= len[k]; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      do_write(addr[k], 4'(k), len[k], BURST_INCR, bresp, bid);
    end
    for (int k = 0; k < 4; k++) begin
      idx = addr[k][9:2];
      for (int i = 0; i <= len[k]; i++) begin
        exp_q.push_back({model_mem[idx], 4'(k + 4), RESP_OKAY, i == len[k]});
        idx = idx + 8'd1;
      end
      do_read(addr[k], 4'(k + 4), len[k], BURST_INCR, k[0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("[TB] FAIL b2b_r: got no beat required %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL b2b_r: got %h required %h", g, e); end end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] bresp;
    logic [3:0] bid;
    logic [17:0] outs;
    beat_t e, g;
    int n;
    wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
    do_write(32'h88, 4'd1, 0, BURST_INCR, bresp, bid);
    AXI_AWADDR = 32'h80; AXI_AWID = 4'd2; AXI_AWLEN = 8'd7; AXI_AWBURST = BURST_INCR; AXI_AWVALID = 1'b1;
    n = 0;
    while (!AXI_AWREADY && n < 100) begin @(negedge clk); n++; end
    if (!AXI_AWREADY) note_timeout("mid_aw");
    @(negedge clk);
    AXI_AWVALID = 1'b0;
    AXI_WSTRB = 4'hF; AXI_WVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      AXI_WDATA = 32'hC0 + 32'(i);
      @(negedge clk);
    end
    // Beat 2 is presented, then reset lands before its clock edge.
    AXI_WDATA = 32'hC2;
    resetn = 1'b0;
    #1;
    outs = {AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_ARREADY, AXI_RVALID, AXI_RLAST,
            AXI_BRESP, AXI_RRESP, AXI_BID, AXI_RID};
    checks++;
    if (outs !== 18'd0) begin errors++; $display("[TB] FAIL mid_reset_outputs: got %h required 0", outs); end
    @(negedge clk);
    AXI_WVALID = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (AXI_AWREADY !== 1'b1) begin errors++; $display("[TB] FAIL mid_awready: got %b required 1", AXI_AWREADY); end
    exp_q.push_back({32'hC0, 4'd3, RESP_OKAY, 1'b0});
    exp_q.push_back({32'hC1, 4'd3, RESP_OKAY, 1'b0});
    exp_q.push_back({32'h12345678, 4'd3, RESP_OKAY, 1'b1});
    do_read(32'h80, 4'd3, 2, BURST_INCR, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("[TB] FAIL mid_reset_r: got no beat required %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL mid_reset_r: got %h required %h", g, e); end end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    AXI_AWADDR = '0; AXI_AWVALID = 0; AXI_AWID = '0; AXI_AWLEN = '0; AXI_AWSIZE = '0;
    AXI_AWBURST = '0; AXI_AWPROT = '0; AXI_AWLOCK = 0; AXI_AWCACHE = '0; AXI_AWQOS = '0;
    AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WLAST = 0; AXI_WVALID = 0; AXI_BREADY = 0;
    AXI_ARADDR = '0; AXI_ARVALID = 0; AXI_ARID = '0; AXI_ARLEN = '0; AXI_ARSIZE = '0;
    AXI_ARBURST = '0; AXI_ARPROT = '0; AXI_ARLOCK = 0; AXI_ARCACHE = '0; AXI_ARQOS = '0;
    AXI_RREADY = 0;
    test_reset();
    test_single();
    test_incr_burst();
    test_strobe_fixed();
    test_wrap_alias();
    test_error_burst();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
